// File: rtl/seq_det_pkg.sv
//==============================================================================
// Module      : seq_det_pkg
// Description : Shared state encoding and default sizing for the programmable
//               serial pattern detector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int c_default_max_len = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    MATCH = 2'd2
  } state_t;

endpackage : seq_det_pkg

`default_nettype wire

// File: rtl/seq_det_cmp.sv
//==============================================================================
// Module      : seq_det_cmp
// Description : Combinational masked compare of shifted history against the
//               programmed pattern; only the low len bits take part.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_det_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] w_mask;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign w_mask[i] = (len > LEN_W'(i));
  end

  assign hit = (((hist ^ pattern) & w_mask) == '0);

endmodule : seq_det_cmp

`default_nettype wire

// File: rtl/seq_detector_prog.sv
//==============================================================================
// Module      : seq_detector_prog
// Description : Runtime-programmable serial pattern detector with registered
//               single-cycle det pulse. Define SEQ_DET_CNT_EN to add the
//               saturating det_cnt match counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = c_default_max_len,
`ifdef SEQ_DET_CNT_EN
  parameter int CNT_W   = 8,
`endif
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               det,
`ifdef SEQ_DET_CNT_EN
  output logic [CNT_W-1:0]   det_cnt,
`endif
  output logic               armed
);

  state_t             r_state, w_state_n;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-2:0] r_hist, w_hist_n;
  logic [LEN_W-1:0]   r_fill, w_fill_n, w_fill_inc;
  logic [MAX_LEN-1:0] w_hist_sh;
  logic               r_det, w_det_n;
  logic               w_cfg_ok, w_step, w_cmp_hit;

  // Illegal lengths leave the detector untouched; an accepted write drops any coincident bit.
  assign w_cfg_ok   = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_step     = in_valid && (r_state != IDLE) && !w_cfg_ok;
  assign w_hist_sh  = {r_hist, in_bit};
  assign w_fill_inc = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (w_hist_sh),
    .pattern (r_pattern),
    .len     (r_len),
    .hit     (w_cmp_hit)
  );

  always_comb begin
    w_state_n = r_state;
    w_fill_n  = r_fill;
    w_hist_n  = r_hist;
    w_det_n   = 1'b0;
    if (w_cfg_ok) begin
      w_state_n = FILL;
      w_fill_n  = '0;
      w_hist_n  = '0;
    end else if (w_step) begin
      w_hist_n = w_hist_sh[MAX_LEN-2:0];
      w_det_n  = (w_fill_inc == r_len) && w_cmp_hit;
      if (w_det_n && !r_overlap) begin
        // Non-overlap: restart so the next match needs len fresh bits.
        w_fill_n  = '0;
        w_state_n = FILL;
      end else begin
        w_fill_n  = w_fill_inc;
        w_state_n = (w_fill_inc == r_len) ? MATCH : FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_fill  <= '0;
      r_hist  <= '0;
      r_det   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_fill  <= w_fill_n;
      r_hist  <= w_hist_n;
      r_det   <= w_det_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
    end else if (w_cfg_ok) begin
      r_pattern <= cfg_pattern;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
    end
  end

  assign det   = r_det;
  assign armed = (r_state != IDLE);

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cfg_ok) begin
      r_cnt <= '0;
    end else if (w_det_n && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign det_cnt = r_cnt;
`endif

endmodule : seq_detector_prog

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
//==============================================================================
// Module      : tb_seq_detector_prog
// Description : Directed self-checking bench for seq_detector_prog.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_detector_prog;

  localparam int c_max_len = 8;
  localparam int c_len_w   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_we = 1'b0;
  logic [c_max_len-1:0] cfg_pattern = '0;
  logic [c_len_w-1:0]   cfg_len = '0;
  logic                 cfg_overlap = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_bit = 1'b0;
  logic                 det;
  logic                 armed;
`ifdef SEQ_DET_CNT_EN
  logic [1:0]           det_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

`ifdef SEQ_DET_CNT_EN
  seq_detector_prog #(.MAX_LEN(c_max_len), .CNT_W(2)) dut (
`else
  seq_detector_prog #(.MAX_LEN(c_max_len)) dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .det         (det),
`ifdef SEQ_DET_CNT_EN
    .det_cnt     (det_cnt),
`endif
    .armed       (armed)
  );

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] bits;
    bits = 4'b1010;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_total++;
    if (det !== 1'b0) $display("FAIL reset_det: det=%b expected 0", det); else n_pass++;
    n_total++;
    if (armed !== 1'b0) $display("FAIL reset_armed: armed=%b expected 0", armed); else n_pass++;
`ifdef SEQ_DET_CNT_EN
    n_total++;
    if (det_cnt !== 2'd0) $display("FAIL reset_cnt: det_cnt=%0d expected 0", det_cnt); else n_pass++;
`endif
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      n_total++;
      if (det !== 1'b0 || armed !== 1'b0)
        $display("FAIL idle_bits[%0d]: det=%b armed=%b expected 0 0", i, det, armed);
      else n_pass++;
    end
  endtask

  task automatic test_overlap;
    logic [5:0] bits, expd;
    bits = 6'b101010;
    expd = 6'b000101;
    do_cfg(8'b1010, 4'd4, 1'b1);
    n_total++;
    if (armed !== 1'b1) $display("FAIL overlap_armed: armed=%b expected 1", armed); else n_pass++;
    for (int i = 5; i >= 0; i--) begin
      send_bit(bits[i]);
      n_total++;
      if (det !== expd[i]) $display("FAIL overlap_det[%0d]: det=%b expected %b", 5 - i, det, expd[i]);
      else n_pass++;
    end
`ifdef SEQ_DET_CNT_EN
    n_total++;
    if (det_cnt !== 2'd2) $display("FAIL overlap_cnt: det_cnt=%0d expected 2", det_cnt); else n_pass++;
`endif
  endtask

  task automatic test_nonoverlap;
    logic [7:0] bits, expd;
    bits = 8'b10101010;
    expd = 8'b00010001;
    do_cfg(8'b1010, 4'd4, 1'b0);
`ifdef SEQ_DET_CNT_EN
    n_total++;
    if (det_cnt !== 2'd0) $display("FAIL cfg_clears_cnt: det_cnt=%0d expected 0", det_cnt); else n_pass++;
`endif
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      n_total++;
      if (det !== expd[i]) $display("FAIL nonoverlap_det[%0d]: det=%b expected %b", 7 - i, det, expd[i]);
      else n_pass++;
    end
  endtask

  task automatic test_gaps;
    logic [3:0] bits, expd;
    bits = 4'b1010;
    expd = 4'b0001;
    do_cfg(8'b1010, 4'd4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      n_total++;
      if (det !== expd[i]) $display("FAIL gap_det[%0d]: det=%b expected %b", 3 - i, det, expd[i]);
      else n_pass++;
      for (int g = 0; g < 3; g++) begin
        idle(1);
        n_total++;
        if (det !== 1'b0) $display("FAIL gap_idle[%0d.%0d]: det=%b expected 0", 3 - i, g, det);
        else n_pass++;
      end
    end
  endtask

  task automatic test_config_edge;
    logic [4:0] b5, e5;
    // Ignored writes (len 0 and len 9) mid-pattern must not disturb history.
    do_cfg(8'b1010, 4'd4, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    do_cfg(8'b1111, 4'd0, 1'b0);
    do_cfg(8'b1111, 4'd9, 1'b0);
    n_total++;
    if (armed !== 1'b1) $display("FAIL badlen_armed: armed=%b expected 1", armed); else n_pass++;
    send_bit(1'b1);
    n_total++;
    if (det !== 1'b0) $display("FAIL badlen_det3: det=%b expected 0", det); else n_pass++;
    send_bit(1'b0);
    n_total++;
    if (det !== 1'b1) $display("FAIL badlen_det4: det=%b expected 1", det); else n_pass++;

    // Config and valid bit together: the bit is dropped.
    cfg_we = 1'b1; cfg_pattern = 8'b1010; cfg_len = 4'd4; cfg_overlap = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    b5 = 5'b01010;
    e5 = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      send_bit(b5[i]);
      n_total++;
      if (det !== e5[i]) $display("FAIL drop_det[%0d]: det=%b expected %b", 4 - i, det, e5[i]);
      else n_pass++;
    end

    // Rewrite mid-stream: history from before the write cannot contribute.
    send_bit(1'b1);
    send_bit(1'b1);
    do_cfg(8'b110, 4'd3, 1'b1);
    send_bit(1'b0);
    n_total++;
    if (det !== 1'b0) $display("FAIL rewrite_span: det=%b expected 0", det); else n_pass++;
    send_bit(1'b1);
    send_bit(1'b1);
    do_cfg(8'b110, 4'd3, 1'b1);
    send_bit(1'b1);
    n_total++;
    if (det !== 1'b0) $display("FAIL rewrite_b1: det=%b expected 0", det); else n_pass++;
    send_bit(1'b1);
    n_total++;
    if (det !== 1'b0) $display("FAIL rewrite_b2: det=%b expected 0", det); else n_pass++;
    send_bit(1'b0);
    n_total++;
    if (det !== 1'b1) $display("FAIL rewrite_b3: det=%b expected 1", det); else n_pass++;
  endtask

  task automatic test_extremes;
    logic [3:0] b4, e4;
    logic [8:0] b9, e9;
    b4 = 4'b1101;
    e4 = 4'b1101;
    do_cfg(8'b1, 4'd1, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      send_bit(b4[i]);
      n_total++;
      if (det !== e4[i]) $display("FAIL len1_det[%0d]: det=%b expected %b", 3 - i, det, e4[i]);
      else n_pass++;
    end

    // Leading 1 then 0xA5: only the ninth bit completes the full-width pattern.
    b9 = 9'b1_1010_0101;
    e9 = 9'b0_0000_0001;
    do_cfg(8'hA5, 4'd8, 1'b0);
    for (int i = 8; i >= 0; i--) begin
      send_bit(b9[i]);
      n_total++;
      if (det !== e9[i]) $display("FAIL maxlen_det[%0d]: det=%b expected %b", 8 - i, det, e9[i]);
      else n_pass++;
    end

    do_cfg(8'b1, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      n_total++;
      if (det !== 1'b1) $display("FAIL sat_det[%0d]: det=%b expected 1", i, det);
      else n_pass++;
    end
`ifdef SEQ_DET_CNT_EN
    n_total++;
    if (det_cnt !== 2'd3) $display("FAIL sat_cnt: det_cnt=%0d expected 3", det_cnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_midrun;
    logic [3:0] bits;
    bits = 4'b1010;
    do_cfg(8'b1010, 4'd4, 1'b1);
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    n_total++;
    if (det !== 1'b1) $display("FAIL prereset_det: det=%b expected 1", det); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (det !== 1'b0 || armed !== 1'b0)
      $display("FAIL async_reset: det=%b armed=%b expected 0 0", det, armed);
    else n_pass++;
`ifdef SEQ_DET_CNT_EN
    n_total++;
    if (det_cnt !== 2'd0) $display("FAIL async_reset_cnt: det_cnt=%0d expected 0", det_cnt); else n_pass++;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      n_total++;
      if (det !== 1'b0 || armed !== 1'b0)
        $display("FAIL postreset[%0d]: det=%b armed=%b expected 0 0", 3 - i, det, armed);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_overlap;
    test_nonoverlap;
    test_gaps;
    test_config_edge;
    test_extremes;
    test_reset_midrun;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_seq_detector_prog

`default_nettype wire
